// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline control slice: widths, the instruction
// register-field positions and the controller state encoding.
package cpu_pkg;

    localparam int unsigned INSTR_W = 8;
    localparam int unsigned REG_W   = 2;
    localparam int unsigned CNT_W   = 8;

    // Source register fields inside the ID instruction
    localparam int unsigned RS_MSB = 3;
    localparam int unsigned RS_LSB = 2;
    localparam int unsigned RT_MSB = 1;
    localparam int unsigned RT_LSB = 0;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: the ID instruction reads a register the
// load currently in EX has not yet returned.
module hazard_detect
    import cpu_pkg::*;
(
    input  logic [INSTR_W-1:0] id_instruction,
    input  logic               id_rs_used,
    input  logic               id_rt_used,
    input  logic               ex_is_load,
    input  logic [REG_W-1:0]   ex_rd,
    output logic               load_use_c
);

    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             rs_hit;
    logic             rt_hit;
    logic             unused_opcode;

    assign rs = id_instruction[RS_MSB:RS_LSB];
    assign rt = id_instruction[RT_MSB:RT_LSB];

    // Opcode bits carry no register dependency
    assign unused_opcode = ^id_instruction[INSTR_W-1:RS_MSB+1];

    assign rs_hit     = id_rs_used && (rs == ex_rd);
    assign rt_hit     = id_rt_used && (rt == ex_rd);
    assign load_use_c = ex_is_load && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: combinational stall/flush/hold decisions from the
// RUN / MEM_WAIT / HALT state plus a saturating stall-cycle counter.
module pipeline_ctrl
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] id_instruction,
    input  logic               id_rs_used,
    input  logic               id_rt_used,
    input  logic               ex_is_load,
    input  logic [REG_W-1:0]   ex_rd,
    input  logic               ex_branch_taken,
    input  logic               mem_busy,
    input  logic               irq,
    input  logic               id_is_halt,
    output logic               pc_write_en,
    output logic               if_id_stall,
    output logic               if_id_flush,
    output logic               id_ex_flush,
    output logic               ex_mem_hold,
    output logic               halted,
    output logic [CNT_W-1:0]   stall_cycles
);

    state_t state;
    state_t state_next;
    logic   load_use;
    logic   stall_req;
    logic   flush_req;

    hazard_detect u_hazard_detect (
        .id_instruction (id_instruction),
        .id_rs_used     (id_rs_used),
        .id_rt_used     (id_rt_used),
        .ex_is_load     (ex_is_load),
        .ex_rd          (ex_rd),
        .load_use_c     (load_use)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state and control outputs; reset overrides everything
    always_comb begin
        state_next  = state;
        pc_write_en = 1'b1;
        stall_req   = 1'b0;
        flush_req   = 1'b0;
        id_ex_flush = 1'b0;
        ex_mem_hold = 1'b0;
        halted      = 1'b0;

        case (state)
            RUN: begin
                if (ex_branch_taken) begin
                    flush_req   = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (mem_busy) begin
                    pc_write_en = 1'b0;
                    stall_req   = 1'b1;
                    ex_mem_hold = 1'b1;
                    state_next  = MEM_WAIT;
                end else if (load_use) begin
                    pc_write_en = 1'b0;
                    stall_req   = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (id_is_halt) begin
                    id_ex_flush = 1'b1;
                    state_next  = HALT;
                end
            end
            MEM_WAIT: begin
                if (mem_busy) begin
                    pc_write_en = 1'b0;
                    stall_req   = 1'b1;
                    ex_mem_hold = 1'b1;
                end else begin
                    state_next = RUN;
                end
            end
            HALT: begin
                halted = 1'b1;
                if (irq) begin
                    flush_req  = 1'b1;
                    state_next = RUN;
                end else begin
                    pc_write_en = 1'b0;
                    stall_req   = 1'b1;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase

        if (rst) begin
            state_next  = RUN;
            pc_write_en = 1'b0;
            stall_req   = 1'b0;
            flush_req   = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_hold = 1'b0;
            halted      = 1'b0;
        end
    end

    // A flush discards the IF/ID contents, so it wins over holding them
    always_comb begin
        if_id_flush = flush_req;
        if_id_stall = stall_req && !flush_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (if_id_stall && (stall_cycles != CNT_MAX)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst, input, width 1: reset, synchronous and active-high.
REQ-003 The block SHALL have the port id_instruction, input, width 8: the instruction held in the IF/ID register.
REQ-004 The block SHALL have the ports id_rs_used and id_rt_used, input, width 1 each: the ID instruction reads field [3:2] (rs) and/or field [1:0] (rt).
REQ-005 The block SHALL have the ports ex_is_load, input, width 1, and ex_rd, input, width 2: the EX instruction is a load, and its destination register.
REQ-006 The block SHALL have the port ex_branch_taken, input, width 1: a branch resolved taken in EX this cycle.
REQ-007 The block SHALL have the port mem_busy, input, width 1: data memory requests a wait cycle.
REQ-008 The block SHALL have the ports irq, input, width 1: wake request, and id_is_halt, input, width 1: the ID instruction is HALT.
REQ-009 The block SHALL have the output ports pc_write_en, if_id_stall, if_id_flush, id_ex_flush and ex_mem_hold, width 1 each: pipeline control signals.
REQ-010 The block SHALL have the output ports halted, width 1, and stall_cycles, width 8: status outputs.

Function
REQ-011 The block SHALL implement a state machine with exactly three states: RUN, MEM_WAIT and HALT.
REQ-012 Control outputs SHALL be combinational from the current state and inputs; there SHALL be zero-cycle latency from an input event to its control response.
REQ-013 In RUN, the default outputs SHALL be pc_write_en=1 and all other controls 0.
REQ-014 In RUN, event priority SHALL be: ex_branch_taken > mem_busy > load-use > id_is_halt.
REQ-015 In RUN, ex_branch_taken SHALL assert if_id_flush=1 and id_ex_flush=1, keep pc_write_en=1, and leave the state in RUN.
REQ-016 In RUN, mem_busy (without a branch) SHALL assert pc_write_en=0, if_id_stall=1 and ex_mem_hold=1, and move the state to MEM_WAIT.
REQ-017 A load-use hazard SHALL be: ex_is_load and ((id_rs_used and rs==ex_rd) or (id_rt_used and rt==ex_rd)).
REQ-018 On a load-use hazard in RUN, the block SHALL assert pc_write_en=0, if_id_stall=1 and id_ex_flush=1 for exactly that cycle, with the state staying in RUN.
REQ-019 In RUN, id_is_halt (no higher-priority event) SHALL assert id_ex_flush=1 and move the state to HALT.
REQ-020 In MEM_WAIT, the block SHALL assert pc_write_en=0, if_id_stall=1 and ex_mem_hold=1 while mem_busy=1.
REQ-021 In MEM_WAIT, the cycle in which mem_busy=0 SHALL produce the RUN defaults and return the state to RUN.
REQ-022 In MEM_WAIT, ex_branch_taken and load-use hazards SHALL be ignored.
REQ-023 In HALT, the block SHALL assert halted=1, pc_write_en=0 and if_id_stall=1.
REQ-024 In HALT, irq=1 SHALL produce if_id_flush=1 and pc_write_en=1 in that cycle and move the state to RUN; all other inputs SHALL be ignored in HALT.
REQ-025 if_id_flush SHALL override if_id_stall whenever both are requested.
REQ-026 stall_cycles SHALL increment by 1 every cycle that if_id_stall=1 and saturate at 255, with no wrap-around.

Reset
REQ-027 When rst=1 at a clock edge, the state SHALL become RUN and stall_cycles SHALL become 0.
REQ-028 Reset SHALL win over every simultaneous event, including reset asserted mid-MEM_WAIT or mid-HALT.
REQ-029 While rst=1, outputs SHALL be pc_write_en=0, if_id_flush=1, id_ex_flush=1, and all others 0.
REQ-030 In the first cycle after rst is released, outputs SHALL be the RUN values.

Structure
REQ-031 The state encoding (2-bit enum RUN/MEM_WAIT/HALT) and the field-slice constants for rs and rt SHALL be defined in the shared package cpu_pkg.
REQ-032 One sub-module, hazard_detect (combinational load-use compare), SHALL be instantiated; all other logic SHALL be local.

Verification
REQ-033 Load-use: ex_is_load=1, ex_rd=2, id_instruction=8'b0000_1000, id_rs_used=1 -> exactly 1 cycle of pc_write_en=0, if_id_stall=1, id_ex_flush=1; stall_cycles goes 0->1.
REQ-034 Branch with hazard: ex_branch_taken=1 in the same cycle as a load-use hazard -> if_id_flush=1, id_ex_flush=1, if_id_stall=0, stall_cycles unchanged.
REQ-035 Memory wait: mem_busy high for 3 cycles -> state MEM_WAIT for 2 cycles, 3 stall cycles, state RUN on the 4th cycle, stall_cycles=3.
REQ-036 Halt: id_is_halt=1 -> halted=1 next cycle; irq pulsed 5 cycles later -> if_id_flush=1 that cycle, then RUN.
REQ-037 Saturation: 300 consecutive stall cycles -> stall_cycles=255 and held there.
REQ-038 Reset mid-wait: rst=1 during MEM_WAIT with mem_busy=1 -> state RUN, stall_cycles=0, reset output values applied.
